// File: rtl/counter_range_pkg.sv
// Shared constants for the programmable-range up/down counter.
package counter_range_pkg;

    localparam int   WIDTH_DEFAULT = 8;
    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;

endpackage

// File: rtl/counter_range_next.sv
// Combinational step rule: next count within [first, last] plus a wrap indication.
module counter_range_next
    import counter_range_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] last,
    input  logic             u_d,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // A wrap only counts as one when the range holds more than a single value;
    // landing on a boundary from outside the range is recovery, not a wrap.
    always_comb begin
        next_count = count;
        wrap       = 1'b0;
        if (first > last) begin
            next_count = first;
        end else if (u_d == DIR_UP) begin
            if (count >= last || count < first) begin
                next_count = first;
                wrap       = (count == last) && (first != last);
            end else begin
                next_count = count + ONE;
            end
        end else begin
            if (count <= first || count > last) begin
                next_count = last;
                wrap       = (count == first) && (first != last);
            end else begin
                next_count = count - ONE;
            end
        end
    end

endmodule

// File: rtl/counter_range_up_down_load.sv
// Up/down counter cycling within [first, last] with synchronous load.
// Optional registered wrap pulse when COUNTER_RANGE_WRAP_FLAG_EN is defined.
module counter_range_up_down_load
    import counter_range_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] last,
    input  logic             load,
    input  logic             u_d,
    output logic [WIDTH-1:0] count
`ifdef COUNTER_RANGE_WRAP_FLAG_EN
    ,
    output logic             wrap
`endif
);

    logic [WIDTH-1:0] step_count;

`ifdef COUNTER_RANGE_WRAP_FLAG_EN
    logic step_wrap;
`endif

    counter_range_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count      (count),
        .first      (first),
        .last       (last),
        .u_d        (u_d),
        .next_count (step_count),
`ifdef COUNTER_RANGE_WRAP_FLAG_EN
        .wrap       (step_wrap)
`else
        .wrap       ()
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= first;
        end else if (load) begin
            count <= (u_d == DIR_UP) ? first : last;
        end else begin
            count <= step_count;
        end
    end

`ifdef COUNTER_RANGE_WRAP_FLAG_EN
    always_ff @(posedge clk) begin
        if (!rst || load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= step_wrap;
        end
    end
`endif

endmodule

// File: tb/tb_counter_range_up_down_load.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares.
// Checks the wrap output too when COUNTER_RANGE_WRAP_FLAG_EN is defined.
module tb_counter_range_up_down_load;
    import counter_range_pkg::*;

    localparam int W = WIDTH_DEFAULT;

    typedef struct {
        int name_id;
        int cnt;
        bit wrp;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] first;
    logic [W-1:0] last;
    logic         load;
    logic         u_d;
    logic [W-1:0] count;
`ifdef COUNTER_RANGE_WRAP_FLAG_EN
    logic         wrap;
`endif

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   m_count = 0;
    int   step_no = 0;

    counter_range_up_down_load #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .first (first),
        .last  (last),
        .load  (load),
        .u_d   (u_d),
        .count (count)
`ifdef COUNTER_RANGE_WRAP_FLAG_EN
        ,
        .wrap  (wrap)
`endif
    );

    always #5 clk = ~clk;

    // Reference: position inside the range advances modulo the range size.
    function automatic void model(input int c, input int f, input int l, input bit r,
                                  input bit ld, input bit d, output int nc, output bit w);
        int n, pos;
        w = 1'b0;
        if (!r)            nc = f;
        else if (ld)       nc = d ? f : l;
        else if (f > l)    nc = f;
        else if (c < f || c > l) nc = d ? f : l;
        else begin
            n   = l - f + 1;
            pos = c - f;
            if (d) begin
                w  = (pos == n - 1) && (n > 1);
                nc = f + (pos + 1) % n;
            end else begin
                w  = (pos == 0) && (n > 1);
                nc = f + (pos - 1 + n) % n;
            end
        end
    endfunction

    task automatic step(input bit r, input bit ld, input bit d, input int f, input int l);
        exp_t e;
        int   nc;
        bit   w;
        @(negedge clk);
        rst = r; load = ld; u_d = d; first = W'(f); last = W'(l);
        model(m_count, f, l, r, ld, d, nc, w);
        m_count   = nc;
        e.name_id = step_no;
        e.cnt     = nc;
        e.wrp     = w;
        q.push_back(e);
        step_no++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (int'(count) != e.cnt) begin
                    n_fail++;
                    $display("FAIL count step %0d: got %0d expected %0d", e.name_id, count, e.cnt);
                end
`ifdef COUNTER_RANGE_WRAP_FLAG_EN
                n_cmp++;
                if (wrap !== e.wrp) begin
                    n_fail++;
                    $display("FAIL wrap step %0d: got %0b expected %0b", e.name_id, wrap, e.wrp);
                end
`endif
            end
        end
    end

    initial begin : driver
        int f, l, mode;
        bit d;
        int guard;
        rst = 1'b0; load = 1'b0; u_d = 1'b1; first = '0; last = '0;

        // reset, up wrap, load mid-count
        step(0, 0, 1, 11, 25);
        step(0, 0, 1, 11, 25);
        repeat (15) step(1, 0, 1, 11, 25);
        repeat (7)  step(1, 0, 1, 11, 25);
        repeat (3)  step(1, 1, 1, 11, 25);
        step(1, 0, 1, 11, 25);
        step(1, 1, 0, 11, 25);
        // down wrap then direction flip
        repeat (12) step(1, 0, 0, 11, 25);
        repeat (4)  step(1, 0, 0, 11, 25);
        repeat (2)  step(1, 0, 1, 11, 25);
        // out-of-range recovery
        step(0, 0, 1, 11, 25);
        repeat (9) step(1, 0, 1, 11, 25);
        step(1, 0, 1, 11, 15);
        // degenerate ranges
        repeat (3) step(1, 0, 1, 7, 7);
        repeat (3) step(1, 0, 0, 7, 7);
        repeat (3) step(1, 0, 1, 30, 10);
        repeat (3) step(1, 0, 0, 30, 10);
        // reset beats load
        step(0, 0, 1, 11, 25);
        repeat (11) step(1, 0, 1, 11, 25);
        step(0, 1, 0, 11, 25);
        step(1, 0, 1, 11, 25);
        // top of the value space
        repeat (6) step(1, 0, 1, 250, 255);
        repeat (6) step(1, 0, 0, 0, 3);

        f = 11; l = 25; d = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                mode = $urandom_range(0, 3);
                case (mode)
                    0: begin f = $urandom_range(0, 20);  l = f + $urandom_range(1, 12); end
                    1: begin f = $urandom_range(245, 254); l = $urandom_range(f + 1, 255); end
                    2: begin f = $urandom_range(0, 40);  l = f; end
                    default: begin f = $urandom_range(0, 255); l = $urandom_range(0, 255); end
                endcase
            end
            if ($urandom_range(0, 9) == 0) d = ~d;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0, d, f, l);
        end

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
